dac_spi_tx: RTL and testbench
=============================

DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 25, sysclk cycles per SCK half-period; legal range 2..255.
REQ-002 Parameter CONFIG, default 4'b0011, 4-bit DAC command nibble sent ahead of data (write, unbuffered, 1x gain, active).
REQ-003 Port sysclk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Port data_in  input  10  unsigned offset-binary sample from the processor stage (its data_out).
REQ-006 Port load  input  1  single-cycle strobe; sample data_in is ready for conversion.
REQ-007 Port busy  output  1  high while a transaction is in progress.
REQ-008 Port dac_cs_n  output  1  DAC chip select, active-low.
REQ-009 Port dac_sck  output  1  serial clock, idle low.
REQ-010 Port dac_sdi  output  1  serial data, MSB first, stable while dac_sck high.
REQ-011 Port dac_ld_n  output  1  DAC latch strobe, active-low.

Function
REQ-012 The block SHALL register all outputs; no combinational path from an input to an output.
REQ-013 The block SHALL implement states IDLE, START, SHIFT, STOP and LATCH.
REQ-014 Each non-IDLE state SHALL be timed by a divider counter; one "half" = CLK_DIV sysclk cycles.
REQ-015 In IDLE, a sampled load=1 SHALL capture shift word {CONFIG, data_in, 2'b00} (16 bits) and enter START on the next edge.
REQ-016 In START (1 half): dac_cs_n=0, dac_sck=0, dac_sdi=word[15], busy=1.
REQ-017 In SHIFT, for each of 16 bits: dac_sck=1 for 1 half, then dac_sck=0 for 1 half.
REQ-018 On each dac_sck falling edge except the 16th, dac_sdi SHALL advance to the next lower bit.
REQ-019 After the 16th low half, the FSM SHALL enter STOP (1 half): dac_cs_n=1, dac_sck=0, dac_sdi=0.
REQ-020 The FSM SHALL then enter LATCH (1 half): dac_ld_n=0.
REQ-021 It SHALL then return to IDLE: dac_ld_n=1, busy=0.
REQ-022 busy SHALL be high for exactly 35*CLK_DIV cycles, starting the cycle after load is sampled.
REQ-023 load asserted while busy=1 SHALL be ignored; no queueing, and the in-flight word SHALL be unchanged.
REQ-024 load asserted in the same cycle busy falls (first IDLE cycle) SHALL be accepted.
REQ-025 data_in changes after capture SHALL NOT affect the in-flight transaction.
REQ-026 The bit counter SHALL count exactly 16 bits; the divider counter SHALL wrap to 0 at CLK_DIV-1.
REQ-027 dac_sck SHALL produce exactly 16 rising edges per transaction.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, busy=0, dac_cs_n=1, dac_sck=0, dac_sdi=0, dac_ld_n=1, and clear all counters and the shift register.
REQ-029 Reset asserted mid-transaction SHALL abort it without a dac_ld_n pulse; the next load after release SHALL start a clean transaction.
REQ-030 On rst_n release, the block SHALL act on the first rising edge with rst_n=1 and accept load from that edge onward.

Verification (CLK_DIV=2 unless stated)
REQ-031 Single load, data_in=10'h200 -> captured frame 16'h3800; busy high 70 cycles; one dac_ld_n low pulse of 2 cycles after dac_cs_n rises.
REQ-032 data_in=10'h3FF, then 10'h000 -> frames 16'h3FFC and 16'h3000; dac_sdi stable on every dac_sck high half.
REQ-033 Second load at cycles 10 and 40 after the first -> ignored; exactly 16 dac_sck rises; frame matches the first data.
REQ-034 Back-to-back: load on the first IDLE cycle -> new transaction starts next edge with no gap beyond the REQ-015 edge.
REQ-035 rst_n pulsed low during bit 7 -> outputs go to reset values asynchronously; no dac_ld_n pulse; next load yields a correct frame.
REQ-036 CLK_DIV=25 -> busy high 875 cycles; SCK period 50 cycles.

Source files
------------

// File: rtl/dac_spi_tx.sv
// Serial transmitter for a 16-bit-frame SPI DAC: command nibble, 10-bit sample, two pad bits,
// followed by an active-low latch strobe once chip select has been released.
module dac_spi_tx #(
    parameter int       CLK_DIV = 25,
    parameter logic [3:0] CONFIG  = 4'b0011
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [9:0] data_in,
    input  logic       load,
    output logic       busy,
    output logic       dac_cs_n,
    output logic       dac_sck,
    output logic       dac_sdi,
    output logic       dac_ld_n
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_STOP  = 3'd3,
        ST_LATCH = 3'd4
    } state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'd15;

    state_e      state_q;
    logic [7:0]  div_q;
    logic [3:0]  bit_q;
    logic [15:0] shreg_q;
    logic        busy_q;
    logic        cs_n_q;
    logic        sck_q;
    logic        sdi_q;
    logic        ld_n_q;
    logic        half_end_s;

    assign half_end_s = (div_q == DIV_LAST);

    assign busy     = busy_q;
    assign dac_cs_n = cs_n_q;
    assign dac_sck  = sck_q;
    assign dac_sdi  = sdi_q;
    assign dac_ld_n = ld_n_q;

    // Transaction FSM: divider, bit counter, shift register and all output registers.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= 8'd0;
            bit_q   <= 4'd0;
            shreg_q <= 16'd0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            ld_n_q  <= 1'b1;
        end else begin
            if ((state_q == ST_IDLE) || half_end_s) begin
                div_q <= 8'd0;
            end else begin
                div_q <= div_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        shreg_q <= {CONFIG, data_in, 2'b00};
                        sdi_q   <= CONFIG[3];
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        sck_q   <= 1'b0;
                        bit_q   <= 4'd0;
                        state_q <= ST_START;
                    end else begin
                        busy_q  <= 1'b0;
                        cs_n_q  <= 1'b1;
                        sck_q   <= 1'b0;
                        sdi_q   <= 1'b0;
                        ld_n_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (half_end_s) begin
                        sck_q   <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (half_end_s) begin
                        if (sck_q) begin
                            // Falling SCK edge: present the next bit, except after the last one.
                            sck_q <= 1'b0;
                            if (bit_q != BIT_LAST) begin
                                shreg_q <= {shreg_q[14:0], 1'b0};
                                sdi_q   <= shreg_q[14];
                            end
                        end else if (bit_q == BIT_LAST) begin
                            cs_n_q  <= 1'b1;
                            sdi_q   <= 1'b0;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            sck_q <= 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (half_end_s) begin
                        ld_n_q  <= 1'b0;
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (half_end_s) begin
                        ld_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    bit_q   <= 4'd0;
                    shreg_q <= 16'd0;
                    busy_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                    sck_q   <= 1'b0;
                    sdi_q   <= 1'b0;
                    ld_n_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: stimulus queues expected frames, a bus monitor
// reassembles frames from the SPI pins and checks busy, latch and SCK behaviour.
module tb_dac_spi_tx;

    localparam int DIV      = 2;
    localparam int BUSY_LEN = 35 * DIV;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic [9:0] data_in;
    logic       load;
    logic       busy, dac_cs_n, dac_sck, dac_sdi, dac_ld_n;

    logic       rst25_n;
    logic [9:0] data25;
    logic       load25;
    logic       busy25, cs25, sck25, sdi25, ld25;
    logic       done25;

    always #5 sysclk = ~sysclk;

    dac_spi_tx #(.CLK_DIV(DIV), .CONFIG(4'b0011)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .data_in(data_in), .load(load),
        .busy(busy), .dac_cs_n(dac_cs_n), .dac_sck(dac_sck), .dac_sdi(dac_sdi), .dac_ld_n(dac_ld_n)
    );

    dac_spi_tx #(.CLK_DIV(25), .CONFIG(4'b0011)) dut25 (
        .sysclk(sysclk), .rst_n(rst25_n), .data_in(data25), .load(load25),
        .busy(busy25), .dac_cs_n(cs25), .dac_sck(sck25), .dac_sdi(sdi25), .dac_ld_n(ld25)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    int          frames_seen = 0;
    int          ld_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus monitor: samples on the falling sysclk edge, away from DUT updates.
    initial begin : monitor
        logic        prev_sck, prev_cs, prev_busy, prev_ld, hi_sdi, unstable;
        logic [15:0] sh;
        logic [15:0] e;
        int          rises, busy_cnt, ld_cnt;
        prev_sck = 1'b0; prev_cs = 1'b1; prev_busy = 1'b0; prev_ld = 1'b1;
        hi_sdi = 1'b0; unstable = 1'b0; sh = 16'd0; rises = 0; busy_cnt = 0; ld_cnt = 0;
        forever begin
            @(negedge sysclk);
            if (rst_n !== 1'b1) begin
                prev_sck = 1'b0; prev_cs = 1'b1; prev_busy = 1'b0; prev_ld = 1'b1;
                unstable = 1'b0; sh = 16'd0; rises = 0; busy_cnt = 0; ld_cnt = 0;
            end else begin
                if (!dac_cs_n && prev_cs) begin
                    sh = 16'd0; rises = 0; unstable = 1'b0;
                end
                if (dac_sck && !prev_sck) begin
                    sh = {sh[14:0], dac_sdi};
                    rises++;
                    hi_sdi = dac_sdi;
                end else if (dac_sck && (dac_sdi !== hi_sdi)) begin
                    unstable = 1'b1;
                end
                if (dac_cs_n && !prev_cs) begin
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        check("frame_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", 32'(sh), 32'(e));
                        check("sck_rises", 32'(rises), 32'd16);
                        check("sdi_stable", 32'(unstable), 32'd0);
                    end
                end
                if (busy) busy_cnt++;
                if (!busy && prev_busy) begin
                    check("busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
                    busy_cnt = 0;
                end
                if (!dac_ld_n) begin
                    if (prev_ld) check("ld_after_cs", 32'(dac_cs_n), 32'd1);
                    ld_cnt++;
                end
                if (dac_ld_n && !prev_ld) begin
                    ld_pulses++;
                    check("ld_width", 32'(ld_cnt), 32'(DIV));
                    ld_cnt = 0;
                end
                prev_sck = dac_sck; prev_cs = dac_cs_n; prev_busy = busy; prev_ld = dac_ld_n;
            end
        end
    end

    task automatic pulse_load(input logic [9:0] d);
        @(negedge sysclk);
        data_in = d;
        load    = 1'b1;
        @(negedge sysclk);
        load    = 1'b0;
        data_in = ~d;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0) && (n < 2000)) begin
            @(negedge sysclk);
            n++;
        end
        if (busy !== 1'b0) check({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    // Slow-divider instance: busy length and SCK period at CLK_DIV=25.
    initial begin : slow_run
        int   cyc, rises, t1, t2, bcnt;
        logic ps;
        cyc = 0; rises = 0; t1 = 0; t2 = 0; bcnt = 0; ps = 1'b0;
        rst25_n = 1'b0; load25 = 1'b0; data25 = 10'd0; done25 = 1'b0;
        #12;
        @(negedge sysclk);
        rst25_n = 1'b1;
        @(negedge sysclk);
        data25 = 10'h200;
        load25 = 1'b1;
        @(negedge sysclk);
        load25 = 1'b0;
        while ((cyc < 3000) && !((bcnt > 0) && !busy25)) begin
            if (busy25) bcnt++;
            if (sck25 && !ps) begin
                rises++;
                if (rises == 1) t1 = cyc;
                if (rises == 2) t2 = cyc;
            end
            ps = sck25;
            @(negedge sysclk);
            cyc++;
        end
        check("div25_busy_len", 32'(bcnt), 32'd875);
        check("div25_sck_period", 32'(t2 - t1), 32'd50);
        check("div25_sck_rises", 32'(rises), 32'd16);
        done25 = 1'b1;
    end

    initial begin : stimulus
        int ld_before, n;
        rst_n = 1'b0; load = 1'b0; data_in = 10'd0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cs_n", 32'(dac_cs_n), 32'd1);
        check("rst_sck", 32'(dac_sck), 32'd0);
        check("rst_sdi", 32'(dac_sdi), 32'd0);
        check("rst_ld_n", 32'(dac_ld_n), 32'd1);
        @(negedge sysclk);
        rst_n = 1'b1;

        exp_q.push_back(16'h3800);
        pulse_load(10'h200);
        wait_idle("t1");

        exp_q.push_back(16'h3FFC);
        pulse_load(10'h3FF);
        wait_idle("t2a");
        exp_q.push_back(16'h3000);
        pulse_load(10'h000);
        wait_idle("t2b");

        // Loads at cycles 10 and 40 into a transaction must be dropped.
        exp_q.push_back(16'h3554);
        pulse_load(10'h155);
        repeat (8) @(negedge sysclk);
        data_in = 10'h0F0; load = 1'b1;
        @(negedge sysclk);
        load = 1'b0;
        repeat (29) @(negedge sysclk);
        data_in = 10'h0F0; load = 1'b1;
        @(negedge sysclk);
        load = 1'b0;
        check("ignored_load_busy", 32'(busy), 32'd1);
        wait_idle("t3");

        // Back-to-back: second load on the first idle cycle.
        exp_q.push_back(16'h3AA8);
        exp_q.push_back(16'h3554);
        pulse_load(10'h2AA);
        wait_idle("t4a");
        data_in = 10'h155; load = 1'b1;
        @(negedge sysclk);
        load = 1'b0; data_in = 10'h000;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_cs_n", 32'(dac_cs_n), 32'd0);
        wait_idle("t4b");

        // Abort during bit 7 with an asynchronous reset pulse.
        ld_before = ld_pulses;
        pulse_load(10'h3FF);
        repeat (30) @(negedge sysclk);
        check("abort_in_high_half", 32'(dac_sck), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cs_n", 32'(dac_cs_n), 32'd1);
        check("abort_sck", 32'(dac_sck), 32'd0);
        check("abort_sdi", 32'(dac_sdi), 32'd0);
        check("abort_ld_n", 32'(dac_ld_n), 32'd1);
        @(negedge sysclk);
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);
        check("abort_no_ld", 32'(ld_pulses), 32'(ld_before));
        exp_q.push_back(16'h348C);
        pulse_load(10'h123);
        wait_idle("t5");

        n = 0;
        while (!done25 && (n < 3000)) begin
            @(negedge sysclk);
            n++;
        end
        if (!done25) check("div25_timeout", 32'(done25), 32'd1);

        repeat (4) @(negedge sysclk);
        check("frames_total", 32'(frames_seen), 32'd7);
        check("ld_total", 32'(ld_pulses), 32'd7);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
